game_phase_sequencer: RTL and testbench

//  Top-level game sequencer that owns the shared board RAM port. It drives the one-hot

---
 rtl/game_phase_sequencer_pkg.sv | 42 ++++
 rtl/game_phase_sequencer_phase_watchdog.sv | 29 ++
 rtl/game_phase_sequencer.sv | 165 ++++++++++++++++
 tb/tb_game_phase_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_phase_sequencer_pkg.sv
// Shared definitions for the game sequencer and its phase engines:
// state encoding, player identities, move position width and board-port selects.
package game_phase_sequencer_pkg;

    localparam int POS_W = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_VALI  = 3'd3;
    localparam logic [2:0] ST_FLIP  = 3'd4;
    localparam logic [2:0] ST_SWAP  = 3'd5;

    localparam logic PLAYER_BLACK = 1'b0;
    localparam logic PLAYER_WHITE = 1'b1;

    typedef struct packed {
        logic init;
        logic vali;
        logic flip;
        logic vga;
    } port_sel_t;

    // States in which a phase engine is running and the watchdog counts.
    function automatic logic is_phase(input logic [2:0] st);
        return (st == ST_INIT) || (st == ST_VALI) || (st == ST_FLIP);
    endfunction

    // Exactly one owner of the board port per state; the VGA reader is the fallback.
    function automatic port_sel_t sel_for_state(input logic [2:0] st);
        port_sel_t s;
        s = '0;
        case (st)
            ST_INIT: s.init = 1'b1;
            ST_VALI: s.vali = 1'b1;
            ST_FLIP: s.flip = 1'b1;
            default: s.vga  = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/game_phase_sequencer_phase_watchdog.sv
// Per-phase watchdog: counts cycles spent in a phase and flags the last allowed cycle.
module phase_watchdog #(
    parameter int TIMEOUT_W = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] ONE  = 1;
    localparam logic [TIMEOUT_W-1:0] LAST = ~ONE;

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ONE;
        end
    end

    // Fires on the cycle whose increment would reach all-ones, so a phase
    // occupies at most 2**TIMEOUT_W-1 cycles before it is abandoned.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/game_phase_sequencer.sv
// Game sequencer: owns the board RAM port selects, runs the init/validate/flip
// engines through start/done handshakes and tracks the player to move.
module game_phase_sequencer #(
    parameter int TIMEOUT_W = 10,
    parameter int POS_W     = game_phase_sequencer_pkg::POS_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_game,
    input  logic             move_req,
    input  logic [POS_W-1:0] move_pos,
    output logic             move_ack,
    output logic             move_rej,
    output logic             init_start,
    input  logic             init_done,
    output logic             vali_start,
    input  logic             vali_done,
    input  logic             vali_legal,
    output logic             flip_start,
    input  logic             flip_done,
    output logic [POS_W-1:0] pos_q,
    output logic             cur_player,
    output logic             init_ctrl,
    output logic             vali_ctrl,
    output logic             flip_ctrl,
    output logic             vga_ctrl,
    output logic             timeout_err
);

    import game_phase_sequencer_pkg::*;

    // Handshake: every *_start is a one-cycle pulse issued together with the
    // matching port select; a *_done pulse is honoured only in its own phase.
    logic [2:0] state;
    logic [2:0] state_nx;
    port_sel_t  sel_q;
    logic       wd_clear;
    logic       wd_expired;

    logic init_fin;
    logic accept_move;
    logic vali_pass;
    logic vali_fail;
    logic flip_fin;
    logic swap_now;
    logic timeout_hit;

    // start_game overrides every event, so each event term is gated by it.
    always_comb begin
        init_fin    = 1'b0;
        accept_move = 1'b0;
        vali_pass   = 1'b0;
        vali_fail   = 1'b0;
        flip_fin    = 1'b0;
        swap_now    = 1'b0;
        timeout_hit = 1'b0;
        state_nx    = state;
        if (start_game) begin
            state_nx = ST_INIT;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_IDLE;
                ST_INIT: begin
                    if (init_done) begin
                        init_fin = 1'b1;
                        state_nx = ST_READY;
                    end else if (wd_expired) begin
                        timeout_hit = 1'b1;
                        state_nx    = ST_IDLE;
                    end
                end
                ST_READY: begin
                    if (move_req) begin
                        accept_move = 1'b1;
                        state_nx    = ST_VALI;
                    end
                end
                ST_VALI: begin
                    if (vali_done && vali_legal) begin
                        vali_pass = 1'b1;
                        state_nx  = ST_FLIP;
                    end else if (vali_done) begin
                        vali_fail = 1'b1;
                        state_nx  = ST_READY;
                    end else if (wd_expired) begin
                        timeout_hit = 1'b1;
                        state_nx    = ST_IDLE;
                    end
                end
                ST_FLIP: begin
                    if (flip_done) begin
                        flip_fin = 1'b1;
                        state_nx = ST_SWAP;
                    end else if (wd_expired) begin
                        timeout_hit = 1'b1;
                        state_nx    = ST_IDLE;
                    end
                end
                ST_SWAP: begin
                    swap_now = 1'b1;
                    state_nx = ST_READY;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // A restart of INIT from INIT is also a fresh entry for the watchdog.
    assign wd_clear = start_game || (state_nx != state);

    phase_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (is_phase(state)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel_q       <= sel_for_state(ST_IDLE);
            init_start  <= 1'b0;
            vali_start  <= 1'b0;
            flip_start  <= 1'b0;
            move_ack    <= 1'b0;
            move_rej    <= 1'b0;
            pos_q       <= '0;
            cur_player  <= PLAYER_BLACK;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nx;
            sel_q      <= sel_for_state(state_nx);
            init_start <= start_game;
            vali_start <= accept_move;
            move_ack   <= accept_move;
            flip_start <= vali_pass;
            move_rej   <= vali_fail;
            if (accept_move) begin
                pos_q <= move_pos;
            end
            if (init_fin) begin
                cur_player <= PLAYER_BLACK;
            end else if (swap_now) begin
                cur_player <= ~cur_player;
            end
            if (start_game) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign init_ctrl = sel_q.init;
    assign vali_ctrl = sel_q.vali;
    assign flip_ctrl = sel_q.flip;
    assign vga_ctrl  = sel_q.vga;

    logic unused_flip_fin;
    assign unused_flip_fin = flip_fin;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a phase-level behavioural model.
module tb_game_phase_sequencer;

    localparam int TW    = 7;
    localparam int PW    = 6;
    localparam int LIMIT = (1 << TW) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_INIT  = 1;
    localparam int S_READY = 2;
    localparam int S_VALI  = 3;
    localparam int S_FLIP  = 4;
    localparam int S_SWAP  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_game = 1'b0;
    logic          move_req = 1'b0;
    logic [PW-1:0] move_pos = '0;
    logic          init_done = 1'b0;
    logic          vali_done = 1'b0;
    logic          vali_legal = 1'b0;
    logic          flip_done = 1'b0;
    logic          move_ack, move_rej, init_start, vali_start, flip_start;
    logic [PW-1:0] pos_q;
    logic          cur_player, init_ctrl, vali_ctrl, flip_ctrl, vga_ctrl, timeout_err;

    always #5 clk = ~clk;

    game_phase_sequencer #(
        .TIMEOUT_W (TW),
        .POS_W     (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_game  (start_game),
        .move_req    (move_req),
        .move_pos    (move_pos),
        .move_ack    (move_ack),
        .move_rej    (move_rej),
        .init_start  (init_start),
        .init_done   (init_done),
        .vali_start  (vali_start),
        .vali_done   (vali_done),
        .vali_legal  (vali_legal),
        .flip_start  (flip_start),
        .flip_done   (flip_done),
        .pos_q       (pos_q),
        .cur_player  (cur_player),
        .init_ctrl   (init_ctrl),
        .vali_ctrl   (vali_ctrl),
        .flip_ctrl   (flip_ctrl),
        .vga_ctrl    (vga_ctrl),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase name, cycles spent in it, and the visible outputs.
    int            m_st = S_IDLE;
    int            m_age = 1;
    bit            m_valid = 1'b0;
    logic          m_player = 1'b0;
    logic          m_terr = 1'b0;
    logic [PW-1:0] m_pos = '0;
    logic          m_is = 1'b0, m_vs = 1'b0, m_fs = 1'b0, m_ack = 1'b0, m_rej = 1'b0;

    always @(posedge clk) begin : model
        int nst;
        m_is = 1'b0; m_vs = 1'b0; m_fs = 1'b0; m_ack = 1'b0; m_rej = 1'b0;
        if (reset) begin
            m_st = S_IDLE; m_age = 1; m_player = 1'b0; m_pos = '0; m_terr = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            nst = m_st;
            if (start_game) begin
                nst = S_INIT; m_is = 1'b1; m_terr = 1'b0;
            end else if (m_st == S_READY) begin
                if (move_req) begin
                    nst = S_VALI; m_pos = move_pos; m_ack = 1'b1; m_vs = 1'b1;
                end
            end else if (m_st == S_SWAP) begin
                nst = S_READY; m_player = ~m_player;
            end else if (m_st == S_INIT && init_done) begin
                nst = S_READY; m_player = 1'b0;
            end else if (m_st == S_VALI && vali_done) begin
                if (vali_legal) begin nst = S_FLIP; m_fs = 1'b1; end
                else begin nst = S_READY; m_rej = 1'b1; end
            end else if (m_st == S_FLIP && flip_done) begin
                nst = S_SWAP;
            end else if ((m_st == S_INIT || m_st == S_VALI || m_st == S_FLIP) && m_age == LIMIT) begin
                nst = S_IDLE; m_terr = 1'b1;
            end
            if (nst != m_st || start_game) m_age = 1;
            else m_age++;
            m_st = nst;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("init_ctrl", init_ctrl, m_st == S_INIT);
            check("vali_ctrl", vali_ctrl, m_st == S_VALI);
            check("flip_ctrl", flip_ctrl, m_st == S_FLIP);
            check("vga_ctrl", vga_ctrl,
                  m_st == S_IDLE || m_st == S_READY || m_st == S_SWAP);
            check("init_start", init_start, m_is);
            check("vali_start", vali_start, m_vs);
            check("flip_start", flip_start, m_fs);
            check("move_ack", move_ack, m_ack);
            check("move_rej", move_rej, m_rej);
            check("pos_q", pos_q, m_pos);
            check("cur_player", cur_player, m_player);
            check("timeout_err", timeout_err, m_terr);
        end
    end

    int n_init_ctrl, n_vali_ctrl, n_flip_ctrl, n_init_start, n_flip_start, n_ack, n_rej;

    always @(negedge clk) begin
        if (init_ctrl)  n_init_ctrl++;
        if (vali_ctrl)  n_vali_ctrl++;
        if (flip_ctrl)  n_flip_ctrl++;
        if (init_start) n_init_start++;
        if (flip_start) n_flip_start++;
        if (move_ack)   n_ack++;
        if (move_rej)   n_rej++;
    end

    task automatic clear_tallies();
        n_init_ctrl = 0; n_vali_ctrl = 0; n_flip_ctrl = 0;
        n_init_start = 0; n_flip_start = 0; n_ack = 0; n_rej = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        clear_tallies();
        reset = 1'b1;
        step(); step();
        check("rst_vga_ctrl", vga_ctrl, 1);
        check("rst_init_ctrl", init_ctrl, 0);
        check("rst_cur_player", cur_player, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        // Game start with a 64-cycle init phase.
        clear_tallies();
        start_game = 1'b1; step(); start_game = 1'b0;
        check("init_start_first", init_start, 1);
        check("init_ctrl_first", init_ctrl, 1);
        repeat (63) step();
        init_done = 1'b1; step(); init_done = 1'b0;
        check("ready_vga", vga_ctrl, 1);
        check("init_ctrl_cycles", n_init_ctrl, 64);
        check("init_start_count", n_init_start, 1);

        // Legal move at cell 19, validated after 10 cycles, flipped after 20.
        clear_tallies();
        move_req = 1'b1; move_pos = 6'd19; step(); move_req = 1'b0; move_pos = '0;
        check("move_pos_latched", pos_q, 19);
        check("move_ack_pulse", move_ack, 1);
        repeat (9) step();
        vali_done = 1'b1; vali_legal = 1'b1; step(); vali_done = 1'b0; vali_legal = 1'b0;
        check("flip_start_pulse", flip_start, 1);
        repeat (19) step();
        flip_done = 1'b1; step(); flip_done = 1'b0;
        check("swap_player_before", cur_player, 0);
        step();
        check("swap_player_after", cur_player, 1);
        check("move_ack_count", n_ack, 1);
        check("flip_start_count", n_flip_start, 1);
        check("vali_ctrl_cycles", n_vali_ctrl, 10);
        check("flip_ctrl_cycles", n_flip_ctrl, 20);

        // Illegal move keeps the player.
        clear_tallies();
        move_req = 1'b1; move_pos = 6'd42; step(); move_req = 1'b0;
        repeat (2) step();
        vali_done = 1'b1; vali_legal = 1'b0; step(); vali_done = 1'b0;
        check("rej_pulse", move_rej, 1);
        check("rej_vga", vga_ctrl, 1);
        check("rej_player", cur_player, 1);
        step();
        check("rej_count", n_rej, 1);
        check("rej_no_flip", n_flip_start, 0);
        check("rej_pos_q", pos_q, 42);

        // Flip never completes: watchdog expires after LIMIT cycles.
        clear_tallies();
        move_req = 1'b1; move_pos = 6'd7; step(); move_req = 1'b0;
        vali_done = 1'b1; vali_legal = 1'b1; step(); vali_done = 1'b0; vali_legal = 1'b0;
        repeat (LIMIT) step();
        check("to_err", timeout_err, 1);
        check("to_vga", vga_ctrl, 1);
        check("to_flip_cycles", n_flip_ctrl, LIMIT);
        flip_done = 1'b1; init_done = 1'b1; move_req = 1'b1; step();
        flip_done = 1'b0; init_done = 1'b0; move_req = 1'b0;
        check("idle_ignores_inputs", vga_ctrl, 1);
        check("idle_no_ack", move_ack, 0);
        start_game = 1'b1; step(); start_game = 1'b0;
        check("restart_clears_err", timeout_err, 0);
        check("restart_init_ctrl", init_ctrl, 1);
        init_done = 1'b1; step(); init_done = 1'b0;
        check("restart_player_black", cur_player, 0);

        // start_game during VALI abandons the phase; move_req then ignored.
        move_req = 1'b1; move_pos = 6'd33; step(); step();
        clear_tallies();
        start_game = 1'b1; step(); start_game = 1'b0;
        check("abort_init_ctrl", init_ctrl, 1);
        check("abort_vali_ctrl", vali_ctrl, 0);
        check("abort_init_start", init_start, 1);
        repeat (3) step();
        move_req = 1'b0;
        check("abort_no_ack", n_ack, 0);

        // Reset mid-phase.
        reset = 1'b1; init_done = 1'b1; step(); reset = 1'b0; init_done = 1'b0;
        check("midrst_vga", vga_ctrl, 1);
        check("midrst_init_ctrl", init_ctrl, 0);

        // Random traffic; every other block of cycles makes done pulses rare so timeouts occur.
        for (int i = 0; i < 4000; i++) begin
            bit quiet;
            quiet      = ((i / 600) % 2) == 1;
            reset      = ($urandom_range(0, 499) == 0);
            start_game = ($urandom_range(0, 79) == 0);
            move_req   = ($urandom_range(0, 1) == 1);
            move_pos   = PW'($urandom_range(0, 63));
            init_done  = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 7) == 0);
            vali_done  = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) == 0);
            vali_legal = ($urandom_range(0, 2) != 0);
            flip_done  = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 5) == 0);
            step();
        end
        reset = 1'b0; start_game = 1'b0; move_req = 1'b0;
        init_done = 1'b0; vali_done = 1'b0; flip_done = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
